// File: rtl/pc_next_unit.sv
// pc_next_unit: MIPS fetch-stage program counter and next-PC selection.
// Forms sequential, branch, jump and jump-register targets, runs the fetch
// handshake with instruction memory and honours pipeline stall.
// Optional feature macro: MISALIGN_TRAP_EN (trap on a misaligned jr target).
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] shifted_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        imem_req,
  output logic        pc_valid,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1
`ifdef MISALIGN_TRAP_EN
    ,
    TRAP = 2'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] next_pc;
  logic [31:0] branch_sum;
  logic        advance;
  logic        trap_take;

  // Sequential address and the fetch-completes condition.
  assign pc_plus_4  = pc + 32'd4;
  assign branch_sum = pc_plus_4 + shifted_offset;
  assign advance    = (state == REQ) && imem_ready && !stall;
  assign pc_valid   = advance;
  assign imem_req   = (state == REQ);

`ifdef MISALIGN_TRAP_EN
  assign trap_take    = advance && jr && (jr_target[1:0] != 2'b00);
  assign misalign_exc = (state == TRAP);
  logic unused_exc;
  assign unused_exc = 1'b0;
`else
  // Without the trap, misaligned jr targets are simply forced to word alignment.
  assign trap_take    = 1'b0;
  assign misalign_exc = 1'b0;
  logic unused_exc;
  assign unused_exc = ^{EXC_VECTOR, jr_target[1:0]};
`endif

  // Next-PC select, priority jr > jump > branch > sequential.
  always_comb begin
    // NOTE: default first so every path assigns next_pc and no latch is inferred.
    next_pc = pc_plus_4;
    if (jr) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus_4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = {branch_sum[31:2], 2'b00};
    end
  end

  // Fetch state transitions.
  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = REQ;
      REQ:  begin
`ifdef MISALIGN_TRAP_EN
        if (trap_take) state_next = TRAP;
`endif
      end
`ifdef MISALIGN_TRAP_EN
      TRAP: state_next = REQ;
`endif
      default: state_next = BOOT;
    endcase
  end

  // State register; reset aborts any fetch in flight.
  // NOTE: reset is in the sensitivity list, so it takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // PC register: loads only on an advance, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (advance) begin
      pc <= trap_take ? EXC_VECTOR : next_pc;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit with an expected-value queue.
module tb_pc_next_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] shifted_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        imem_req;
  logic        pc_valid;
  logic        misalign_exc;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        exc;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pc_next_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .shifted_offset (shifted_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .jr             (jr),
    .jr_target      (jr_target),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .imem_req       (imem_req),
    .pc_valid       (pc_valid),
    .misalign_exc   (misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check pc_valid before the edge, queue the
  // expected post-edge state and compare it after the edge.
  task automatic step(input string tag, input logic st, input logic rdy,
                      input logic br, input logic [31:0] off,
                      input logic j, input logic [25:0] idx,
                      input logic jrr, input logic [31:0] tgt,
                      input logic exp_valid, input logic [31:0] exp_pc,
                      input logic exp_req, input logic exp_exc);
    exp_t e;
    stall = st; imem_ready = rdy; branch_taken = br; shifted_offset = off;
    jump = j; jump_index = idx; jr = jrr; jr_target = tgt;
    #1;
    check({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, exp_valid});
    e.pc = exp_pc; e.req = exp_req; e.exc = exp_exc; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"}, pc, e.pc);
      check({e.tag, ".req"}, {31'd0, imem_req}, {31'd0, e.req});
      check({e.tag, ".exc"}, {31'd0, misalign_exc}, {31'd0, e.exc});
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; shifted_offset = '0;
    jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por.pc", pc, 32'h0000_0000);
    check("por.req", {31'd0, imem_req}, 32'd0);
    check("por.exc", {31'd0, misalign_exc}, 32'd0);
    reset = 1'b0;
    #1;
    check("boot0.req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("boot0_done.req", {31'd0, imem_req}, 32'd1);

    // Move to 0x40 then reset in the middle of a fetch cycle.
    step("jr_40", 0, 1, 0, 0, 0, 0, 1, 32'h0000_0040, 1, 32'h0000_0040, 1, 0);
    jr = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_async.pc", pc, 32'h0000_0000);
    check("rst_async.req", {31'd0, imem_req}, 32'd0);
    check("rst_async.valid", {31'd0, pc_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("boot.req", {31'd0, imem_req}, 32'd0);
    check("boot.valid", {31'd0, pc_valid}, 32'd0);
    @(posedge clk); #1;
    check("boot_done.pc", pc, 32'h0000_0000);
    step("seq_4", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 0);
    step("seq_8", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0008, 1, 0);

    // Branch with a negative offset.
    step("jr_100", 0, 1, 0, 0, 0, 0, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 0);
    step("br_neg", 0, 1, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 1, 32'h0000_00F4, 1, 0);

    // Jump target and priority.
    step("jr_4010", 0, 1, 0, 0, 0, 0, 1, 32'h4000_0010, 1, 32'h4000_0010, 1, 0);
    step("jump", 0, 1, 0, 0, 1, 26'h000_0040, 0, 0, 1, 32'h4000_0100, 1, 0);
    step("jr_4010b", 0, 1, 0, 0, 0, 0, 1, 32'h4000_0010, 1, 32'h4000_0010, 1, 0);
    step("jump_br", 0, 1, 1, 32'h0000_0020, 1, 26'h000_0040, 0, 0, 1, 32'h4000_0100, 1, 0);
    step("jr_all", 0, 1, 1, 32'h0000_0020, 1, 26'h000_0040, 1, 32'h0000_2000, 1, 32'h0000_2000, 1, 0);

    // Stall with ready, then ready low; redirects presented must be ignored.
    for (int i = 0; i < 3; i++)
      step("stall", 1, 1, 1, 32'h0000_0040, 1, 26'h3FF_FFFF, 1, 32'h0000_3000, 0, 32'h0000_2000, 1, 0);
    for (int i = 0; i < 2; i++)
      step("not_ready", 0, 0, 0, 0, 1, 26'h3FF_FFFF, 0, 0, 0, 32'h0000_2000, 1, 0);
    step("resume", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_2004, 1, 0);

    // Wrap-around at the top of the address space.
    step("jr_top", 0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0);
    check("top.pc_plus_4", pc_plus_4, 32'h0000_0000);
    step("wrap", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 0);
    check("wrap.pc_plus_4", pc_plus_4, 32'h0000_0004);

    // Misaligned jr.
`ifdef MISALIGN_TRAP_EN
    step("jr_mis", 0, 1, 0, 0, 0, 0, 1, 32'h0000_1002, 1, 32'h8000_0180, 0, 1);
    step("trap_exit", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0180, 1, 0);
    step("post_trap", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0184, 1, 0);
`else
    step("jr_mis", 0, 1, 0, 0, 0, 0, 1, 32'h0000_1002, 1, 32'h0000_1000, 1, 0);
    step("post_mis", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1004, 1, 0);
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC selection for the MIPS fetch stage.
- Sits directly downstream of shift_left_2: consumes the word-aligned branch offset (sign-extended immediate << 2) and adds it to PC+4 for branch targets.
- Also forms jump and jump-register targets.
- Runs a small fetch handshake with instruction memory, honours pipeline stall, and traps misaligned register jumps.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on a misaligned jr trap (used only with MISALIGN_TRAP_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit freeze; holds PC and ignores redirects.
- branch_taken  input  1  branch resolved taken this cycle.
- shifted_offset  input  32  branch byte offset from shift_left_2.
- jump  input  1  j/jal redirect.
- jump_index  input  26  instr[25:0] for j/jal.
- jr  input  1  jr/jalr redirect.
- jr_target  input  32  register jump address.
- imem_ready  input  1  instruction memory has returned the word at pc.
- pc  output  32  current fetch address, registered.
- pc_plus_4  output  32  pc + 4, combinational, modulo 2^32.
- imem_req  output  1  fetch request for the word at pc.
- pc_valid  output  1  fetch of pc completes this cycle.
- misalign_exc  output  1  one-cycle pulse on a misaligned jr trap.

Behaviour:
- Reset (async, any state):
  - pc=RESET_VECTOR, state=BOOT.
  - imem_req=0, pc_valid=0, misalign_exc=0.
- Reset asserted mid-fetch aborts the fetch. No redirect is retained.
- States:
  - BOOT: imem_req=0. Goes to REQ on the next clk edge unconditionally.
  - REQ: imem_req=1. Advance condition is imem_ready=1 AND stall=0. On advance, pc<=next_pc and the block stays in REQ. Otherwise pc is held.
  - TRAP: entered on an advance that selects a misaligned jr. Here imem_req=0 and misalign_exc=1 for exactly this one cycle, and pc=EXC_VECTOR already. Goes to REQ on the next edge.
- pc_valid = (state==REQ) & imem_ready & ~stall. It is combinational and is 0 in BOOT and TRAP.
- Redirect inputs are sampled only on an advance cycle. When not advancing they are ignored and not latched; upstream holds them.
- next_pc priority, highest first: jr > jump > branch_taken > sequential.
  - jr: jr_target.
  - jump: {pc_plus_4[31:28], jump_index, 2'b00}.
  - branch: pc_plus_4 + shifted_offset, 32-bit, carry discarded. A negative offset wraps modulo 2^32.
  - sequential: pc_plus_4.
- Wrap-around: pc=32'hFFFF_FFFC sequentially advances to 32'h0000_0000.
- Simultaneous jr+jump+branch_taken: jr wins; no error.
- Stall together with imem_ready: no advance; pc and state are held.
- pc[1:0] is always 2'b00 after any advance.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On an advance with jr=1 and jr_target[1:0]!=0: pc<=EXC_VECTOR, state<=TRAP, misalign_exc pulses 1 for one cycle.
  - Aligned jr behaves normally.
- Undefined:
  - jr target used as {jr_target[31:2], 2'b00}.
  - TRAP state is absent; misalign_exc is tied to 0.
  - EXC_VECTOR is unused.

Test Plan:
- Reset/boot sequence:
  - Stimulus: assert reset mid-cycle with pc=32'h0000_0040, release, then imem_ready=1 constantly.
  - Required response:
    - pc=0 immediately, async.
    - First cycle after release: imem_req=0 (BOOT).
    - Then pc steps 0, 4, 8, with pc_valid=1 each cycle.
- Branch with negative offset:
  - Stimulus: pc=32'h0000_0100, branch_taken=1, shifted_offset=32'hFFFF_FFF0, advance.
  - Required response: pc=32'h0000_00F4.
- Jump and priority:
  - Stimulus 1: pc=32'h4000_0010, jump=1, jump_index=26'h000_0040.
  - Required response 1: pc=32'h4000_0100.
  - Stimulus 2: same cycle with branch_taken=1.
  - Required response 2: still 32'h4000_0100.
  - Stimulus 3: jr=1, jr_target=32'h0000_2000.
  - Required response 3: pc=32'h0000_2000 regardless of jump/branch.
- Stall and handshake:
  - Stimulus: stall=1 for 3 cycles with imem_ready=1, then imem_ready=0 for 2 cycles with stall=0.
  - Required response: pc unchanged throughout, pc_valid=0, imem_req=1. pc advances only on the first cycle with ready=1 and stall=0.
- Wrap:
  - Stimulus: pc=32'hFFFF_FFFC, sequential advance.
  - Required response: pc=32'h0000_0000, pc_plus_4=32'h0000_0004.
- Misaligned jr:
  - Stimulus: jr_target=32'h0000_1002, advance.
  - Required response with MISALIGN_TRAP_EN: pc=32'h8000_0180, misalign_exc=1 for one cycle, imem_req=0 that cycle, then REQ.
  - Required response without the macro: pc=32'h0000_1000, misalign_exc=0.
